// File: rtl/fifo_ser_pkg.sv
// Shared types and sizing for the FIFO word serializer.
// Default geometry lives here so the bench and the RTL agree.
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SEND  = 2'd3
  } ser_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int BYTES_PER_WORD = DATA_W_DEF / BYTE_W_DEF;
  localparam int BIDX_W = $clog2(BYTES_PER_WORD);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer.sv
// Pops words from a sync FIFO read port and streams them out
// as bytes on a valid/ready interface with a last-byte marker.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BYTE_W    = BYTE_W_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);

  localparam int N  = DATA_W / BYTE_W;
  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if ((DATA_W % BYTE_W) != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of BYTE_W");
  end

  ser_state_e        state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [IW-1:0]     bidx_q, bidx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bidx_q  <= bidx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bidx_d  = bidx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      // read data is valid one cycle after the pop
      LOAD: begin
        sreg_d  = fifo_rdata;
        bidx_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (m_ready) begin
          if (bidx_q == LAST_IDX) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
          end else begin
            bidx_d = bidx_q + IW'(1);
            sreg_d = MSB_FIRST ? (sreg_q << BYTE_W)
                               : (sreg_q >> BYTE_W);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  if (MSB_FIRST) begin : g_msb
    assign m_data = sreg_q[DATA_W-1 -: BYTE_W];
  end else begin : g_lsb
    assign m_data = sreg_q[BYTE_W-1:0];
  end

  assign fifo_ren = (state_q == FETCH);
  assign m_valid  = (state_q == SEND);
  assign m_last   = m_valid && (bidx_q == LAST_IDX);
  assign busy     = (state_q != IDLE);
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: behavioural sync FIFOs feeding an MSB-first
// and an LSB-first serializer, with byte capture monitors.
module tb_fifo_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_ready = 1'b0;

  logic        fe0, ren0, mv0, ml0, busy0;
  logic        fe1, ren1, mv1, ml1, busy1;
  logic [31:0] rd0 = '0, rd1 = '0;
  logic [7:0]  md0, md1;
  logic [15:0] wc0, wc1;

  logic        wr0 = 1'b0, wr1 = 1'b0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic [4:0]  wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_word_serializer #(
    .DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b1), .CNT_W(16)
  ) u_msb (
    .clk(clk), .rst(rst),
    .fifo_empty(fe0), .fifo_ren(ren0), .fifo_rdata(rd0),
    .m_valid(mv0), .m_ready(m_ready), .m_data(md0),
    .m_last(ml0), .word_cnt(wc0), .busy(busy0)
  );

  fifo_word_serializer #(
    .DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b0), .CNT_W(16)
  ) u_lsb (
    .clk(clk), .rst(rst),
    .fifo_empty(fe1), .fifo_ren(ren1), .fifo_rdata(rd1),
    .m_valid(mv1), .m_ready(m_ready), .m_data(md1),
    .m_last(ml1), .word_cnt(wc1), .busy(busy1)
  );

  assign fe0 = (wp0 == rp0);
  assign fe1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (wr0) begin
      mem0[wp0[3:0]] <= wd0;
      wp0 <= wp0 + 5'd1;
    end
    if (ren0) begin
      rd0 <= mem0[rp0[3:0]];
      rp0 <= rp0 + 5'd1;
    end
    if (wr1) begin
      mem1[wp1[3:0]] <= wd1;
      wp1 <= wp1 + 5'd1;
    end
    if (ren1) begin
      rd1 <= mem1[rp1[3:0]];
      rp1 <= rp1 + 5'd1;
    end
  end

  logic [7:0] by0 [256];
  logic       lt0 [256];
  int         cy0 [256];
  logic [7:0] by1 [256];
  logic       lt1 [256];
  int nb0 = 0, nb1 = 0;
  int nren0 = 0, nval0 = 0, bad_ren = 0, cyc = 0;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (rst) begin
      if (ren0) nren0++;
      if (mv0) nval0++;
      if ((ren0 && fe0) || (ren1 && fe1)) bad_ren++;
      if (mv0 && m_ready && nb0 < 256) begin
        by0[nb0] = md0;
        lt0[nb0] = ml0;
        cy0[nb0] = cyc;
        nb0++;
      end
      if (mv1 && m_ready && nb1 < 256) begin
        by1[nb1] = md1;
        lt1[nb1] = ml1;
        nb1++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] d);
    @(negedge clk);
    if (k == 0) begin
      wr0 = 1'b1;
      wd0 = d;
    end else begin
      wr1 = 1'b1;
      wd1 = d;
    end
    @(negedge clk);
    wr0 = 1'b0;
    wr1 = 1'b0;
  endtask

  task automatic wait_wc(input int k, input int target);
    int n = 0;
    while (((k == 0) ? int'(wc0) : int'(wc1)) != target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_word_cnt", (k == 0) ? 32'(wc0) : 32'(wc1), 32'(target));
  endtask

  task automatic wait_valid0();
    int n = 0;
    while (!mv0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(mv0), 32'd1);
  endtask

  logic [31:0] w;
  int b, r;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(mv0), 32'd0);
    chk("rst_ren", 32'(ren0), 32'd0);
    chk("rst_last", 32'(ml0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_data", 32'(md0), 32'd0);
    chk("rst_cnt", 32'(wc0), 32'd0);
    rst = 1'b1;

    r = nren0;
    b = nval0;
    repeat (50) @(negedge clk);
    chk("empty_ren", 32'(nren0 - r), 32'd0);
    chk("empty_valid", 32'(nval0 - b), 32'd0);
    chk("empty_cnt", 32'(wc0), 32'd0);

    m_ready = 1'b1;
    b = nb0;
    r = nren0;
    push(0, 32'hCAFEBABE);
    wait_wc(0, 1);
    w = 32'hCAFEBABE;
    for (int i = 0; i < 4; i++) begin
      chk("cafe_byte", 32'(by0[b+i]), 32'(w[31-8*i -: 8]));
      chk("cafe_last", 32'(lt0[b+i]), (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++)
      chk("cafe_gap", 32'(cy0[b+i+1] - cy0[b+i]), 32'd1);
    chk("cafe_nbytes", 32'(nb0 - b), 32'd4);
    chk("cafe_ren", 32'(nren0 - r), 32'd1);
    chk("cafe_busy", 32'(busy0), 32'd0);

    b = nb1;
    push(1, 32'hCAFEBABE);
    wait_wc(1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("lsb_byte", 32'(by1[b+i]), 32'(w[8*i +: 8]));
      chk("lsb_last", 32'(lt1[b+i]), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("lsb_busy", 32'(busy1), 32'd0);

    b = nb0;
    r = nren0;
    for (int i = 1; i <= 8; i++) push(0, 32'(i));
    wait_wc(0, 9);
    for (int i = 0; i < 32; i++)
      chk("burst_byte", 32'(by0[b+i]),
          ((i % 4) == 3) ? 32'(i / 4 + 1) : 32'd0);
    chk("burst_nbytes", 32'(nb0 - b), 32'd32);
    chk("burst_ren", 32'(nren0 - r), 32'd8);
    chk("burst_empty", 32'(fe0), 32'd1);
    chk("burst_busy", 32'(busy0), 32'd0);

    m_ready = 1'b0;
    b = nb0;
    push(0, 32'h11223344);
    wait_valid0();
    chk("bp_first", 32'(md0), 32'h11);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", 32'(md0), 32'h22);
      chk("bp_hold_valid", 32'(mv0), 32'd1);
      chk("bp_hold_last", 32'(ml0), 32'd0);
      @(negedge clk);
    end
    chk("bp_still", 32'(md0), 32'h22);
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", 32'(md0), 32'h33);
    wait_wc(0, 10);
    chk("bp_b0", 32'(by0[b]), 32'h11);
    chk("bp_b1", 32'(by0[b+1]), 32'h22);
    chk("bp_b3", 32'(by0[b+3]), 32'h44);
    chk("bp_last", 32'(lt0[b+3]), 32'd1);
    chk("bp_nbytes", 32'(nb0 - b), 32'd4);

    push(0, 32'hA1B2C3D4);
    wait_valid0();
    chk("rm_b0", 32'(md0), 32'hA1);
    @(negedge clk);
    chk("rm_b1", 32'(md0), 32'hB2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rm_valid", 32'(mv0), 32'd0);
    chk("rm_data", 32'(md0), 32'd0);
    chk("rm_last", 32'(ml0), 32'd0);
    chk("rm_ren", 32'(ren0), 32'd0);
    chk("rm_busy", 32'(busy0), 32'd0);
    chk("rm_cnt", 32'(wc0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rm_cnt_after", 32'(wc0), 32'd0);
    b = nb0;
    push(0, 32'h55667788);
    wait_wc(0, 1);
    chk("rm_new_b0", 32'(by0[b]), 32'h55);
    chk("rm_new_b3", 32'(by0[b+3]), 32'h88);
    chk("rm_new_nbytes", 32'(nb0 - b), 32'd4);

    chk("ren_while_empty", 32'(bad_ren), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
Drain stage sitting directly downstream of fifo_sync. Pops 32-bit words from the FIFO read port (fifo_ren / fifo_empty / fifo_rdata) and emits each word as a sequence of bytes on a valid/ready byte stream, with a last-byte marker and a completed-word counter. Absorbs the FIFO's 1-cycle read latency and all downstream backpressure.

Parameters:
DATA_W, 32, FIFO word width; must be a multiple of BYTE_W
BYTE_W, 8, output beat width
MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant first
CNT_W, 16, width of word_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
fifo_empty  in  1  FIFO empty flag
fifo_ren  out  1  FIFO read enable, one-cycle pulse per word
fifo_rdata  in  DATA_W  FIFO read data, valid the cycle after fifo_ren
m_valid  out  1  output byte valid
m_ready  in  1  downstream accepts byte when m_valid && m_ready at posedge
m_data  out  BYTE_W  output byte
m_last  out  1  high with the final byte of each word
word_cnt  out  CNT_W  count of fully transmitted words
busy  out  1  high in any state other than IDLE

Behaviour:
- Async reset (rst=0): state=IDLE. fifo_ren, m_valid, m_last, busy = 0; m_data, word_cnt, shift register, byte index = 0. Reset in the middle of a word discards that word; no partial completion is counted.
- All outputs are registered or pure Moore decodes of state. No combinational path from m_ready to fifo_ren.
- FSM states:
  IDLE: if !fifo_empty -> FETCH, else stay.
  FETCH: fifo_ren=1 for exactly this cycle -> LOAD.
  LOAD: capture fifo_rdata into shift reg; byte_idx=0 -> SEND.
  SEND: m_valid=1.
    On handshake with byte_idx < N-1: shift, byte_idx++, stay in SEND.
    On handshake with byte_idx == N-1: word_cnt++, m_valid drops next cycle -> IDLE.
- N = DATA_W/BYTE_W (4 at defaults).
- m_data: MSB_FIRST=1 sends [DATA_W-1 -: BYTE_W] first, then shifts left. MSB_FIRST=0 sends [BYTE_W-1:0] first, then shifts right.
- m_last = m_valid && byte_idx == N-1.
- Backpressure: while m_valid && !m_ready, m_data, m_last and byte_idx hold stable. There is no timeout.
- Min cost per word: 3 overhead cycles (IDLE, FETCH, LOAD) + N accepted beats → 7 cycles/word at defaults with m_ready tied high.
- fifo_ren is never asserted while fifo_empty=1. This block is the sole reader, so fifo_empty cannot rise between IDLE and FETCH.
- word_cnt wraps 2^CNT_W-1 -> 0 silently.
- m_ready may toggle arbitrarily. m_ready asserted with m_valid=0 has no effect.
- DATA_W not a multiple of BYTE_W is a parameter error; reject it with an elaboration-time check.

Decomposition:
- Shared package fifo_ser_pkg holds:
  - state enum {IDLE, FETCH, LOAD, SEND}, 2-bit encoding
  - localparam BYTES_PER_WORD = DATA_W/BYTE_W
  - byte-index width $clog2(BYTES_PER_WORD)
- No sub-module needed; the FSM and shift register live in one module. The bench instantiates fifo_sync + fifo_word_serializer back to back.

Test Plan:
- Reset, write 32'hCAFEBABE, m_ready=1 → bytes CA,FE,BA,BE on consecutive cycles; m_last only on BE; exactly one fifo_ren pulse; word_cnt=1; busy returns to 0.
- MSB_FIRST=0, same word → BE,BA,FE,CA; m_last on CA.
- FIFO kept empty for 50 cycles → fifo_ren never 1, m_valid never 1, word_cnt=0.
- Write 8 words 1..8, m_ready=1 → 32 bytes in order, 8 fifo_ren pulses, word_cnt=8, FIFO empty at end.
- Backpressure: m_ready=0 for 5 cycles at byte 2 of 32'h11223344 → m_data holds 8'h22 with m_valid=1 throughout; stream resumes with 8'h33.
- Assert rst=0 after 2 bytes of 32'hA1B2C3D4 → all outputs 0 immediately (async); after release, next FIFO word is sent from byte 0; word_cnt=0.
